alu_decoder_mext: RTL and testbench
===================================

Name: alu_decoder_mext

Overview:
- Next-generation ALU control decoder for the RV32 core. Decodes ALUOp/funct3/funct7 into a wider ALUControl code covering the full RV32I ALU set (SRA, SLT, SLTU, signed/unsigned branch compares) plus the RV32M ops.
- Adds a multi-cycle sequencer for MUL/DIV/REM. It holds the control code stable, pulses start to the M-unit, and stalls the pipeline for a parametrised number of cycles.
- Sits between the main decoder and the ALU/M-unit in the execute stage.

Parameters:
- CTRL_W, 5, ALUControl width; must be >= 5.
- MUL_CYCLES, 4, total cycles for MUL/MULH/MULHSU/MULHU; must be >= 1.
- DIV_CYCLES, 33, total cycles for DIV/DIVU/REM/REMU; must be >= 1.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- valid_i  in  1  execute-stage instruction valid.
- flush_i  in  1  pipeline flush; aborts any M-op in progress.
- op5  in  1  instr[5] (1 = R-type, 0 = I-type).
- ALUOp  in  2  00 = add, 01 = branch, 10 = R/I arithmetic, 11 = reserved.
- funct3  in  3  instr[14:12].
- funct7_5  in  1  instr[30].
- funct7_0  in  1  instr[25] (M-extension select).
- div_zero_i  in  1  divisor == 0, from the operand path.
- ALUControl  out  CTRL_W  ALU / M-unit operation code.
- is_muldiv  out  1  current op is an M-op.
- md_start  out  1  one-cycle start pulse to the M-unit.
- md_done  out  1  one-cycle pulse in the M-op's final cycle.
- stall_o  out  1  hold IF/ID/EX.

Behaviour:
- Codes: 0x00 ADD, 0x01 SLL, 0x02 SUB, 0x04 XOR, 0x05 SRL, 0x06 OR, 0x07 AND, 0x08 SRA, 0x09 SLT, 0x0A SLTU.
- M-op codes: 0x10 + funct3 (0x10 MUL … 0x17 REMU). Upper bits are zero-extended to CTRL_W.
- ALUOp 00 gives ADD.
- ALUOp 01 (branch):
  - funct3 000/001 gives SUB.
  - 100/101 gives SLT.
  - 110/111 gives SLTU.
  - 010/011 gives ADD.
- ALUOp 10, funct3 000: SUB iff op5 & funct7_5, else ADD.
- ALUOp 10, funct3 101: SRA iff funct7_5, else SRL.
- ALUOp 10, funct3 010 gives SLT; 011 gives SLTU; remaining funct3 values map as the base set.
- ALUOp 10 with op5 & funct7_0 & !funct7_5 is an M-op: is_muldiv = 1 and code = 0x10 + funct3.
- ALUOp 11 gives ADD.
- Non-M ops: ALUControl is combinational from the inputs, zero latency. is_muldiv, md_start, md_done and stall_o are 0.
- FSM states: IDLE, BUSY. Down-counter cnt is wide enough for DIV_CYCLES-1. A registered op_q holds the latched code.
- IDLE, when valid_i & M-op & !flush_i is accepted in cycle T:
  - md_start = 1 in T.
  - N = MUL_CYCLES if funct3[2] = 0, else DIV_CYCLES. If funct3[2] = 1 and div_zero_i = 1, N = 1 (spec result, no iteration).
  - If N == 1: md_done = 1 in T, stall_o = 0, stay in IDLE.
  - Else: stall_o = 1 in T, cnt <= N-2, op_q <= code, go to BUSY.
- BUSY:
  - ALUControl = op_q and is_muldiv = 1; live inputs are ignored.
  - While cnt != 0: stall_o = 1, cnt decrements.
  - When cnt == 0: md_done = 1, stall_o = 0, go to IDLE.
  - Net effect: md_done at T+N-1, stall_o high T..T+N-2.
- Back-to-back M-ops: the cycle after md_done is IDLE and can accept a new op. md_start is never asserted while in BUSY.
- flush_i in BUSY: go to IDLE next edge. No md_done. stall_o drops that same cycle.
- flush_i in IDLE: suppresses acceptance, so md_start = 0.
- valid_i = 0: no acceptance, but ALUControl still decodes combinationally.
- Reset (async assert, any state): state = IDLE, cnt = 0, op_q = ADD. Outputs while reset is asserted: md_start = md_done = stall_o = 0, is_muldiv = 0, ALUControl = ADD (0).
- Reset mid-BUSY: the op is abandoned with no md_done.

Decomposition:
- Shared package `alu_ctrl_pkg` holds:
  - ALUControl code localparams (ALU_ADD … ALU_REMU).
  - ALUOp encodings.
  - FSM state encoding.
  - CTRL_W default.
- One sub-module, `alu_ctrl_comb`, does the pure combinational decode to {code, is_muldiv}.
- The top holds the FSM, counter and op_q, and the output mux between the live decode and op_q.

Test Plan:
- Base R-type sweep: ALUOp=10, op5=1, all funct3 with funct7_5 ∈ {0,1}. Expect SUB=0x02 for 000/1, SRA=0x08 for 101/1, SLTU=0x0A for 011, zero-cycle response, stall_o = 0 throughout.
- Branch decode: ALUOp=01 with funct3 000, 100, 110. Expect 0x02, 0x09, 0x0A respectively.
- MUL with MUL_CYCLES=4, accepted at cycle 10:
  - md_start at 10.
  - stall_o high 10–12.
  - md_done at 13 with ALUControl = 0x10 held 10–13 while funct3 inputs toggle.
  - New DIV accepted at 14.
- DIVU with DIV_CYCLES=33 and div_zero_i=0: stall_o high for 32 cycles and md_done at T+32. Repeat with div_zero_i=1: md_start and md_done both in T, stall_o = 0.
- flush_i at T+5 of a DIV: state returns to IDLE, no md_done, stall_o = 0 from T+5. The next M-op is accepted normally.
- rst pulled low asynchronously mid-BUSY (between clock edges): outputs go to 0 immediately. After release, a MUL completes in exactly MUL_CYCLES cycles.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the RV32IM ALU control decoder: operation codes,
// ALUOp encodings and sequencer states.
package alu_ctrl_pkg;

  localparam int CTRL_W_DEF = 5;
  localparam int CODE_W     = 5;

  typedef logic [CODE_W-1:0] code_t;

  localparam code_t ALU_ADD    = 5'h00;
  localparam code_t ALU_SLL    = 5'h01;
  localparam code_t ALU_SUB    = 5'h02;
  localparam code_t ALU_XOR    = 5'h04;
  localparam code_t ALU_SRL    = 5'h05;
  localparam code_t ALU_OR     = 5'h06;
  localparam code_t ALU_AND    = 5'h07;
  localparam code_t ALU_SRA    = 5'h08;
  localparam code_t ALU_SLT    = 5'h09;
  localparam code_t ALU_SLTU   = 5'h0A;
  localparam code_t ALU_MUL    = 5'h10;
  localparam code_t ALU_MULH   = 5'h11;
  localparam code_t ALU_MULHSU = 5'h12;
  localparam code_t ALU_MULHU  = 5'h13;
  localparam code_t ALU_DIV    = 5'h14;
  localparam code_t ALU_DIVU   = 5'h15;
  localparam code_t ALU_REM    = 5'h16;
  localparam code_t ALU_REMU   = 5'h17;

  typedef enum logic [1:0] {
    ALUOP_ADD    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_ARITH  = 2'b10,
    ALUOP_RSVD   = 2'b11
  } aluop_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/alu_ctrl_comb.sv
// Pure combinational decode of ALUOp/funct3/funct7 into an ALU or M-unit code.
import alu_ctrl_pkg::*;

module alu_ctrl_comb (
  input  logic       op5_i,
  input  logic [1:0] alu_op_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  input  logic       funct7_0_i,
  output code_t      code_o,
  output logic       is_md_o
);

  always_comb begin
    // NOTE: every output gets a default before the case so no path can infer a latch.
    code_o  = ALU_ADD;
    is_md_o = 1'b0;
    case (aluop_e'(alu_op_i))
      ALUOP_BRANCH: begin
        case (funct3_i[2:1])
          2'b00:   code_o = ALU_SUB;
          2'b01:   code_o = ALU_ADD;
          2'b10:   code_o = ALU_SLT;
          default: code_o = ALU_SLTU;
        endcase
      end
      ALUOP_ARITH: begin
        if (op5_i && funct7_0_i && !funct7_5_i) begin
          is_md_o = 1'b1;
          case (funct3_i)
            3'b000:  code_o = ALU_MUL;
            3'b001:  code_o = ALU_MULH;
            3'b010:  code_o = ALU_MULHSU;
            3'b011:  code_o = ALU_MULHU;
            3'b100:  code_o = ALU_DIV;
            3'b101:  code_o = ALU_DIVU;
            3'b110:  code_o = ALU_REM;
            default: code_o = ALU_REMU;
          endcase
        end else begin
          // funct7_5 only selects SUB for register forms; ADDI has no such bit.
          case (funct3_i)
            3'b000:  code_o = (op5_i && funct7_5_i) ? ALU_SUB : ALU_ADD;
            3'b001:  code_o = ALU_SLL;
            3'b010:  code_o = ALU_SLT;
            3'b011:  code_o = ALU_SLTU;
            3'b100:  code_o = ALU_XOR;
            3'b101:  code_o = funct7_5_i ? ALU_SRA : ALU_SRL;
            3'b110:  code_o = ALU_OR;
            default: code_o = ALU_AND;
          endcase
        end
      end
      ALUOP_ADD, ALUOP_RSVD: code_o = ALU_ADD;
      default:               code_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/alu_decoder_mext.sv
// Execute-stage ALU control decoder with a stall sequencer for multi-cycle
// MUL/DIV/REM operations.
import alu_ctrl_pkg::*;

module alu_decoder_mext #(
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush_i,
  input  logic              op5,
  input  logic [1:0]        ALUOp,
  input  logic [2:0]        funct3,
  input  logic              funct7_5,
  input  logic              funct7_0,
  input  logic              div_zero_i,
  output logic [CTRL_W-1:0] ALUControl,
  output logic              is_muldiv,
  output logic              md_start,
  output logic              md_done,
  output logic              stall_o
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'((MUL_CYCLES > 1) ? MUL_CYCLES - 2 : 0);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'((DIV_CYCLES > 1) ? DIV_CYCLES - 2 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  code_t            op_q, op_d;

  code_t dec_code;
  logic  dec_md;
  code_t code_mux;
  logic  md_mux, start_c, done_c, stall_c;
  logic  accept, single_cycle;

  alu_ctrl_comb u_comb (
    .op5_i      (op5),
    .alu_op_i   (ALUOp),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .funct7_0_i (funct7_0),
    .code_o     (dec_code),
    .is_md_o    (dec_md)
  );

  assign accept = valid_i && dec_md && !flush_i;
  // A divide by zero returns its architected result without iterating.
  assign single_cycle = funct3[2] ? (div_zero_i || (DIV_CYCLES == 1))
                                  : (MUL_CYCLES == 1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    code_mux = dec_code;
    md_mux   = dec_md;
    start_c  = 1'b0;
    done_c   = 1'b0;
    stall_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          start_c = 1'b1;
          if (single_cycle) begin
            done_c = 1'b1;
          end else begin
            stall_c = 1'b1;
            cnt_d   = funct3[2] ? DIV_LOAD : MUL_LOAD;
            op_d    = dec_code;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        code_mux = op_q;
        md_mux   = 1'b1;
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          done_c  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= ALU_ADD;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // Outputs are forced quiet for the whole time reset is held, not just after an edge.
  assign ALUControl = rst ? CTRL_W'(code_mux) : '0;
  assign is_muldiv  = rst && md_mux;
  assign md_start   = rst && start_c;
  assign md_done    = rst && done_c;
  assign stall_o    = rst && stall_c;

endmodule

// File: tb/tb_alu_decoder_mext.sv
// Self-checking bench for alu_decoder_mext: decode table, directed M-op
// sequences (flush, reset, div-by-zero) and randomized traffic against a model.
module tb_alu_decoder_mext;

  logic       clk;
  logic       rst;
  logic       valid_i, flush_i, op5, funct7_5, funct7_0, div_zero_i;
  logic [1:0] ALUOp;
  logic [2:0] funct3;
  logic [4:0] ALUControl;
  logic       is_muldiv, md_start, md_done, stall_o;

  int n_checks = 0;
  int n_err    = 0;

  alu_decoder_mext #(.CTRL_W(5), .MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .flush_i    (flush_i),
    .op5        (op5),
    .ALUOp      (ALUOp),
    .funct3     (funct3),
    .funct7_5   (funct7_5),
    .funct7_0   (funct7_0),
    .div_zero_i (div_zero_i),
    .ALUControl (ALUControl),
    .is_muldiv  (is_muldiv),
    .md_start   (md_start),
    .md_done    (md_done),
    .stall_o    (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] aluop;
    logic       op5;
    logic [2:0] f3;
    logic       f75;
    logic       f70;
    logic [4:0] code;
    logic       md;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [4:0] code, input logic md,
                            input logic start, input logic done, input logic stall);
    check({tag, ".code"},  32'(ALUControl), 32'(code));
    check({tag, ".md"},    32'(is_muldiv),  32'(md));
    check({tag, ".start"}, 32'(md_start),   32'(start));
    check({tag, ".done"},  32'(md_done),    32'(done));
    check({tag, ".stall"}, 32'(stall_o),    32'(stall));
  endtask

  task automatic drive(input logic v, input logic fl, input logic [1:0] aop, input logic o5,
                       input logic [2:0] f3, input logic f75, input logic f70, input logic dz);
    valid_i = v; flush_i = fl; ALUOp = aop; op5 = o5;
    funct3 = f3; funct7_5 = f75; funct7_0 = f70; div_zero_i = dz;
  endtask

  task automatic drive_mop(input logic [2:0] f3, input logic dz, input logic fl);
    drive(1'b1, fl, 2'b10, 1'b1, f3, 1'b0, 1'b1, dz);
  endtask

  task automatic drive_garbage();
    drive(1'($urandom_range(0, 1)), 1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)));
  endtask

  // Issue one M-op from IDLE and follow it for n cycles while the live inputs churn.
  task automatic run_mop(input logic [2:0] f3, input logic dz, input int n, input string tag);
    logic [4:0] ec;
    ec = {2'b10, f3};
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      if (k == 0) drive_mop(f3, dz, 1'b0);
      else        drive_garbage();
      #1;
      check_outs($sformatf("%s[%0d]", tag, k), ec, 1'b1, k == 0, k == n - 1, k < n - 1);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] aop, input logic o5, input logic [2:0] f3,
                              input logic f75, input logic f70, input logic [4:0] code,
                              input logic md);
    vec_t v;
    v.aluop = aop; v.op5 = o5; v.f3 = f3; v.f75 = f75; v.f70 = f70; v.code = code; v.md = md;
    return v;
  endfunction

  // Reference decode written straight from the opcode rules.
  function automatic logic [5:0] ref_decode(input logic [1:0] aop, input logic o5,
                                            input logic [2:0] f3, input logic f75,
                                            input logic f70);
    int base[8];
    int br[4];
    int code;
    base = '{0, 1, 9, 10, 4, 5, 6, 7};
    br   = '{2, 0, 9, 10};
    if (aop == 2'b10) begin
      if (o5 && f70 && !f75) return {1'b1, 5'(16 + int'(f3))};
      code = base[f3];
      if (f3 == 3'd0 && o5 && f75) code = 2;
      if (f3 == 3'd5 && f75) code = 8;
      return {1'b0, 5'(code)};
    end
    if (aop == 2'b01) return {1'b0, 5'(br[f3[2:1]])};
    return 6'd0;
  endfunction

  // Model state: cycles still owed by an accepted multi-cycle op, and its code.
  int         m_left = 0;
  logic [4:0] m_code = 5'd0;

  task automatic model_check(input string tag);
    logic [5:0] d;
    logic [4:0] e_code;
    logic       e_md, e_start, e_done, e_stall;
    int         n;
    e_start = 1'b0; e_done = 1'b0; e_stall = 1'b0;
    if (m_left > 0) begin
      e_code = m_code; e_md = 1'b1;
      if (flush_i) m_left = 0;
      else if (m_left == 1) begin e_done = 1'b1; m_left = 0; end
      else begin e_stall = 1'b1; m_left--; end
    end else begin
      d = ref_decode(ALUOp, op5, funct3, funct7_5, funct7_0);
      e_code = d[4:0]; e_md = d[5];
      if (valid_i && e_md && !flush_i) begin
        e_start = 1'b1;
        n = funct3[2] ? (div_zero_i ? 1 : 33) : 4;
        if (n == 1) e_done = 1'b1;
        else begin e_stall = 1'b1; m_left = n - 1; m_code = e_code; end
      end
    end
    check_outs(tag, e_code, e_md, e_start, e_done, e_stall);
  endtask

  initial begin
    vecs.push_back(mk(2'b10, 1, 3'd0, 0, 0, 5'h00, 0));
    vecs.push_back(mk(2'b10, 1, 3'd0, 1, 0, 5'h02, 0));
    vecs.push_back(mk(2'b10, 1, 3'd1, 0, 0, 5'h01, 0));
    vecs.push_back(mk(2'b10, 1, 3'd1, 1, 0, 5'h01, 0));
    vecs.push_back(mk(2'b10, 1, 3'd2, 0, 0, 5'h09, 0));
    vecs.push_back(mk(2'b10, 1, 3'd2, 1, 0, 5'h09, 0));
    vecs.push_back(mk(2'b10, 1, 3'd3, 0, 0, 5'h0A, 0));
    vecs.push_back(mk(2'b10, 1, 3'd3, 1, 0, 5'h0A, 0));
    vecs.push_back(mk(2'b10, 1, 3'd4, 0, 0, 5'h04, 0));
    vecs.push_back(mk(2'b10, 1, 3'd4, 1, 0, 5'h04, 0));
    vecs.push_back(mk(2'b10, 1, 3'd5, 0, 0, 5'h05, 0));
    vecs.push_back(mk(2'b10, 1, 3'd5, 1, 0, 5'h08, 0));
    vecs.push_back(mk(2'b10, 1, 3'd6, 0, 0, 5'h06, 0));
    vecs.push_back(mk(2'b10, 1, 3'd6, 1, 0, 5'h06, 0));
    vecs.push_back(mk(2'b10, 1, 3'd7, 0, 0, 5'h07, 0));
    vecs.push_back(mk(2'b10, 1, 3'd7, 1, 0, 5'h07, 0));
    vecs.push_back(mk(2'b01, 0, 3'd0, 0, 0, 5'h02, 0));
    vecs.push_back(mk(2'b01, 0, 3'd4, 0, 0, 5'h09, 0));
    vecs.push_back(mk(2'b01, 0, 3'd6, 0, 0, 5'h0A, 0));
    vecs.push_back(mk(2'b01, 0, 3'd3, 0, 0, 5'h00, 0));
    vecs.push_back(mk(2'b10, 0, 3'd0, 1, 0, 5'h00, 0));
    vecs.push_back(mk(2'b10, 0, 3'd5, 1, 0, 5'h08, 0));
    vecs.push_back(mk(2'b00, 1, 3'd5, 1, 1, 5'h00, 0));
    vecs.push_back(mk(2'b11, 1, 3'd7, 0, 1, 5'h00, 0));
    vecs.push_back(mk(2'b10, 0, 3'd0, 0, 1, 5'h00, 0));
    vecs.push_back(mk(2'b10, 1, 3'd0, 1, 1, 5'h02, 0));
    vecs.push_back(mk(2'b10, 1, 3'd0, 0, 1, 5'h10, 1));
    vecs.push_back(mk(2'b10, 1, 3'd7, 0, 1, 5'h17, 1));

    // Reset asserted with a valid M-op on the inputs: everything must be quiet.
    rst = 1'b0;
    drive_mop(3'd4, 1'b0, 1'b0);
    #3;
    check_outs("reset", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outs("reset_sub", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // Decode table; M-op rows are presented with valid low so nothing starts.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(!vecs[i].md, 1'b0, vecs[i].aluop, vecs[i].op5, vecs[i].f3,
            vecs[i].f75, vecs[i].f70, 1'b0);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].code, vecs[i].md, 1'b0, 1'b0, 1'b0);
    end

    // MUL then an immediate back-to-back DIV, DIVU, DIVU by zero, MULH with div_zero set.
    run_mop(3'd0, 1'b0, 4,  "mul");
    run_mop(3'd4, 1'b0, 33, "div_b2b");
    run_mop(3'd5, 1'b0, 33, "divu");
    run_mop(3'd5, 1'b1, 1,  "divu_zero");
    run_mop(3'd1, 1'b1, 4,  "mulh_dz");

    // Flush on the sixth cycle of a DIV.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) drive_mop(3'd4, 1'b0, 1'b0);
      else        drive_garbage();
      #1;
      check_outs($sformatf("flush_pre[%0d]", k), 5'h14, 1'b1, k == 0, 1'b0, 1'b1);
    end
    @(negedge clk);
    drive_mop(3'd1, 1'b0, 1'b1);
    #1;
    check_outs("flush_cyc", 5'h14, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 1'b0, 2'b10, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0);
    #1;
    check_outs("flush_after", 5'h06, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mop(3'd2, 1'b0, 4, "post_flush");

    // Flush and valid_i low both block acceptance in IDLE.
    @(negedge clk);
    drive_mop(3'd0, 1'b0, 1'b1);
    #1;
    check_outs("idle_flush", 5'h10, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b0, 2'b10, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0);
    #1;
    check_outs("idle_novalid", 5'h16, 1'b1, 1'b0, 1'b0, 1'b0);
    run_mop(3'd3, 1'b0, 4, "after_idle");

    // Asynchronous reset between clock edges in the middle of a MUL.
    @(negedge clk);
    drive_mop(3'd0, 1'b0, 1'b0);
    #1;
    check_outs("rst_mid[0]", 5'h10, 1'b1, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    check_outs("rst_mid[1]", 5'h10, 1'b1, 1'b0, 1'b0, 1'b1);
    #1;
    rst = 1'b0;
    #1;
    check_outs("rst_async", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    #1;
    check_outs("rst_release", 5'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    run_mop(3'd0, 1'b0, 4, "mul_after_rst");

    // Randomized traffic against the reference model.
    m_left = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 29) == 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) begin
        ALUOp = 2'b10; op5 = 1'b1; funct7_0 = 1'b1; funct7_5 = 1'b0;
      end
      #1;
      model_check($sformatf("rand%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
